// File: rtl/bcd_rtc_core.sv
// bcd_rtc_core: BCD time/calendar clock with jiffy counter, hh:mm:ss alarm, periodic/alarm IRQ and read-hold snapshot
module bcd_rtc_core #(
  parameter int CLK_HZ = 14318180,
  parameter int SUBSEC = 60
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic [64:0] RTC,
  input  logic [3:0]  ADDR,
  input  logic        WE,
  input  logic        RD,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        IRQ_N
);
  localparam int DIV = CLK_HZ / SUBSEC;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [7:0] JIF_MAX = 8'(SUBSEC - 1);

  // Digit-wise BCD increment; a ones digit >= 9 carries, tens >= 9 wraps to 0.
  function automatic logic [7:0] binc(input logic [7:0] v);
    return v[3:0] >= 4'd9 ? {(v[7:4] >= 4'd9 ? 4'd0 : v[7:4] + 4'd1), 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] jif_q, jif_d, year_q, year_d;
  logic [6:0] sec_q, sec_d, min_q, min_d, asec_q, asec_d, amin_q, amin_d;
  logic [5:0] hour_q, hour_d, date_q, date_d, ahour_q, ahour_d;
  logic [4:0] mon_q, mon_d;
  logic [2:0] dow_q, dow_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic pf_q, pf_d, af_q, af_d, chk_q, chk_d, irq_n_q, irq_n_d, tgl_q, tgl_d;
  logic [42:0] rtc_q, rtc_d;
  logic [7:0] shd_q [8];
  logic [7:0] shd_d [8];
  logic [7:0] live [16];
  logic [7:0] sec_i, min_i, hour_i, date_i, mon_i, year_i;
  logic [15:0] wa, wt;
  logic [5:0] mlen;
  logic ld, tick, sc, sec_c, min_c, hour_c, date_c, mon_c, leap, clr, cap;
  logic unused_rtc;

  assign unused_rtc = ^{RTC[63:51], RTC[39:37], RTC[31:30], RTC[23:22], RTC[15], RTC[7]};

  always_comb begin
    live = '{default: 8'h00};
    live[0] = {1'b0, sec_q};
    live[1] = {1'b0, min_q};
    live[2] = {2'b0, hour_q};
    live[3] = {5'b0, dow_q};
    live[4] = {2'b0, date_q};
    live[5] = {3'b0, mon_q};
    live[6] = year_q;
    live[7] = jif_q;
    live[8] = {1'b0, asec_q};
    live[9] = {1'b0, amin_q};
    live[10] = {2'b0, ahour_q};
    live[11] = {4'b0, ctrl_q};
    live[12] = {6'b0, af_q, pf_q};
  end

  assign DATA_OUT = (ctrl_q[0] && !ADDR[3]) ? shd_q[ADDR[2:0]] : live[ADDR];
  assign IRQ_N = irq_n_q;

  always_comb begin
    rtc_d = {RTC[64], RTC[50:48], RTC[47:40], RTC[36:32], RTC[29:24], RTC[21:16], RTC[14:8], RTC[6:0]};
    ld = tgl_q != rtc_q[42];
    tgl_d = rtc_q[42];
    wa = WE ? 16'd1 << ADDR : 16'd0;
    wt = ld ? 16'd0 : wa;
    leap = year_q[4] ? (year_q[3:0] == 4'd2 || year_q[3:0] == 4'd6)
                     : (year_q[3:0] == 4'd0 || year_q[3:0] == 4'd4 || year_q[3:0] == 4'd8);
    mlen = mon_q == 5'h02 ? (leap ? 6'h29 : 6'h28)
         : (mon_q == 5'h04 || mon_q == 5'h06 || mon_q == 5'h09 || mon_q == 5'h11) ? 6'h30 : 6'h31;
    tick = !ctrl_q[3] && pre_q == PRE_MAX;
    sc = tick && jif_q >= JIF_MAX;
    sec_c = sc && sec_q[3:0] >= 4'd9 && sec_q[6:4] >= 3'd5;
    min_c = sec_c && min_q[3:0] >= 4'd9 && min_q[6:4] >= 3'd5;
    hour_c = min_c && hour_q >= 6'h23;
    date_c = hour_c && date_q >= mlen;
    mon_c = date_c && mon_q >= 5'h12;
    sec_i = binc({1'b0, sec_q});
    min_i = binc({1'b0, min_q});
    hour_i = binc({2'b0, hour_q});
    date_i = binc({2'b0, date_q});
    mon_i = binc({3'b0, mon_q});
    year_i = binc(year_q);
    pre_d = (ld || wt[0]) ? '0 : ctrl_q[3] ? pre_q : tick ? '0 : pre_q + PW'(1);
    jif_d = (ld || wt[0] || sc) ? 8'd0 : tick ? jif_q + 8'd1 : jif_q;
    // Load beats write beats tick; a written field still lets the tick carry ripple onward.
    sec_d = ld ? rtc_q[6:0] : wt[0] ? DATA_IN[6:0] : sc ? (sec_c ? 7'h00 : sec_i[6:0]) : sec_q;
    min_d = ld ? rtc_q[13:7] : wt[1] ? DATA_IN[6:0] : sec_c ? (min_c ? 7'h00 : min_i[6:0]) : min_q;
    hour_d = ld ? rtc_q[19:14] : wt[2] ? DATA_IN[5:0] : min_c ? (hour_c ? 6'h00 : hour_i[5:0]) : hour_q;
    dow_d = ld ? rtc_q[41:39] : wt[3] ? DATA_IN[2:0] : hour_c ? (dow_q >= 3'd6 ? 3'd0 : dow_q + 3'd1) : dow_q;
    date_d = ld ? rtc_q[25:20] : wt[4] ? DATA_IN[5:0] : hour_c ? (date_c ? 6'h01 : date_i[5:0]) : date_q;
    mon_d = ld ? rtc_q[30:26] : wt[5] ? DATA_IN[4:0] : date_c ? (mon_c ? 5'h01 : mon_i[4:0]) : mon_q;
    year_d = ld ? rtc_q[38:31] : wt[6] ? DATA_IN : mon_c ? year_i : year_q;
    asec_d = wa[8] ? DATA_IN[6:0] : asec_q;
    amin_d = wa[9] ? DATA_IN[6:0] : amin_q;
    ahour_d = wa[10] ? DATA_IN[5:0] : ahour_q;
    ctrl_d = wa[11] ? DATA_IN[3:0] : ctrl_q;
    clr = RD && ADDR == 4'hC;
    chk_d = sc && !ld;
    pf_d = chk_d || (pf_q && !clr);
    af_d = (chk_q && sec_q == asec_q && min_q == amin_q && hour_q == ahour_q) || (af_q && !clr);
    irq_n_d = !((pf_q && ctrl_q[1]) || (af_q && ctrl_q[2]));
    cap = wa[11] && DATA_IN[0] && !ctrl_q[0];
    for (int i = 0; i < 8; i++) shd_d[i] = cap ? live[i] : shd_q[i];
  end

  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      pre_q <= '0;
      jif_q <= 8'd0;
      sec_q <= 7'h00;
      min_q <= 7'h00;
      hour_q <= 6'h00;
      dow_q <= 3'd0;
      date_q <= 6'h01;
      mon_q <= 5'h01;
      year_q <= 8'h00;
      asec_q <= 7'h00;
      amin_q <= 7'h00;
      ahour_q <= 6'h00;
      ctrl_q <= 4'h0;
      pf_q <= 1'b0;
      af_q <= 1'b0;
      chk_q <= 1'b0;
      irq_n_q <= 1'b1;
      rtc_q <= rtc_d;
      tgl_q <= RTC[64];
      shd_q <= '{default: 8'h00};
    end else begin
      pre_q <= pre_d;
      jif_q <= jif_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hour_q <= hour_d;
      dow_q <= dow_d;
      date_q <= date_d;
      mon_q <= mon_d;
      year_q <= year_d;
      asec_q <= asec_d;
      amin_q <= amin_d;
      ahour_q <= ahour_d;
      ctrl_q <= ctrl_d;
      pf_q <= pf_d;
      af_q <= af_d;
      chk_q <= chk_d;
      irq_n_q <= irq_n_d;
      rtc_q <= rtc_d;
      tgl_q <= tgl_d;
      shd_q <= shd_d;
    end
  end
endmodule
